y86_execute_stage: RTL
======================

Name: y86_execute_stage

Overview:
- Execute (E) pipeline stage of the Y86-64 core.
- Sits directly downstream of decode and wraps the existing 64-bit `alu` (2-bit control: 00 add, 01 sub, 10 and, 11 xor; `carry_overflow` flag).
- Selects ALU operands per instruction, holds the condition-code register (ZF/SF/OF), evaluates branch/cmov conditions, and registers results into the E→M pipeline register with a valid/ready handshake.

Parameters:
- WORD_W, 64, data path width (must match `alu`).
- RNONE, 4'hF, register ID meaning "no destination".

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept this cycle
- flush  in  1  squash: discard the output register and any same-cycle accept
- icode  in  4  Y86 icode (0 HALT … B POPQ)
- ifun  in  4  function code
- valA  in  WORD_W  operand A
- valB  in  WORD_W  operand B
- valC  in  WORD_W  constant
- dstE  in  4  ALU-result destination register
- dstM  in  4  memory-result destination register
- out_valid  out  1  E→M register holds an instruction
- out_ready  in  1  memory stage consumes
- out_icode  out  4  registered icode
- out_cnd  out  1  condition result
- out_valE  out  WORD_W  ALU result
- out_valA  out  WORD_W  pass-through valA
- out_dstE  out  4  dstE, forced to RNONE for a non-taken cmov
- out_dstM  out  4  pass-through dstM
- cc_zf, cc_sf, cc_of  out  1 each  condition-code register

Behaviour:
- Reset (reset_n=0 at clk edge):
  - out_valid=0; all out_* data outputs 0; out_dstE=out_dstM=RNONE.
  - cc_zf=1, cc_sf=0, cc_of=0.
  - Reset overrides flush and accept.
- Handshake:
  - in_ready = !out_valid | out_ready.
  - Accept = in_valid & in_ready & !flush.
  - Latency is 1 cycle: an accepted instruction appears on out_* at the next edge with out_valid=1.
  - When out_valid & !out_ready, out_* hold stable and in_ready=0.
  - When out_ready without a new accept, out_valid→0.
- flush: at the next edge out_valid=0 and CC is unchanged, regardless of in_valid/out_ready.
- Operand select (ALU computes aluB OP aluA; `alu` is driven a=aluB, b=aluA):
  - OPq (6): aluA=valA, aluB=valB, control=ifun[1:0].
  - RRMOVQ/CMOVXX (2): aluA=valA, aluB=0, add.
  - IRMOVQ (3), RMMOVQ (4), MRMOVQ (5): aluA=valC; aluB=0 for IRMOVQ, else valB; add.
  - CALL (8), PUSHQ (A): aluA=-8, aluB=valB, add.
  - RET (9), POPQ (B): aluA=+8, aluB=valB, add.
  - Other icodes: valE=0.
  - Arithmetic wraps modulo 2^64.
- CC update:
  - Occurs only on an accepted OPq, at the same edge as the output register.
  - ZF = (valE==0).
  - SF = valE[63].
  - OF = carry_overflow for add/sub, 0 for and/xor.
- Cnd (JXX=7, CMOVXX=2) uses the CC value before the edge. By ifun:
  - 0: 1
  - 1 (le): (SF^OF)|ZF
  - 2 (l): SF^OF
  - 3 (e): ZF
  - 4 (ne): !ZF
  - 5 (ge): !(SF^OF)
  - 6 (g): !(SF^OF)&!ZF
  - ifun>6: 0
  - Other icodes: Cnd=1.
- CMOVXX with Cnd=0: out_dstE=RNONE.
- Back-to-back OPq followed by JXX: the JXX sees the CC written by the OPq, which was accepted in an earlier cycle.

Optional Feature:
- Macro: Y86_EXEC_STATS_EN.
- Defined:
  - Adds outputs stat_instr[31:0] (accepted instructions) and stat_taken[31:0] (accepted JXX with Cnd=1).
  - Both counters saturate at 32'hFFFFFFFF, reset to 0, and are not incremented on flush cycles.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package y86_pkg:
  - icode localparams (I_HALT … I_POPQ).
  - ALU control codes (ALU_ADD=2'b00, ALU_SUB, ALU_AND, ALU_XOR).
  - Condition ifun codes.
  - RNONE.
- Sub-module y86_cond_eval: combinational (ifun, zf, sf, of) → cnd.
- Existing `alu` instantiated unchanged.

Test Plan:
- Reset, then OPq add valA=1 valB=3 → next cycle out_valE=4, ZF=0, SF=0, OF=0; before the op, CC reads ZF=1.
- OPq sub valA=99876 valB=-2456 → out_valE=-102332, SF=1, ZF=0; then JXX ifun=2 (l) → out_cnd=1; JXX ifun=3 (e) → out_cnd=0.
- OPq add valA=valB=64'h4000_0000_0000_0000 → OF=1, SF=1; then xor valA=valB=5 → valE=0, ZF=1, OF=0.
- CMOVXX ifun=4 (ne) after ZF=1, dstE=3 → out_dstE=RNONE; PUSHQ valB=0x100 → out_valE=0xF8; POPQ valB=0x100 → 0x108.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and out_* stable; release → next instruction follows 1 cycle later.
- flush in the same cycle as an accepted OPq → out_valid=0 next cycle and CC unchanged; reset_n=0 mid-stream → out_valid=0 and CC={1,0,0} at the next edge.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: shared constants for the Y86-64 execute stage.
//   - icode values (I_HALT .. I_POPQ)
//   - ALU control codes understood by `alu`
//   - condition ifun codes for JXX / CMOVXX
//   - R_NONE register ID ("no destination")
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;  // also CMOVXX
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [3:0] R_NONE = 4'hF;

endpackage

// File: rtl/alu.sv
// alu: existing combinational ALU of the core.
//   a, b            operands; result = a OP b
//   control         00 add, 01 sub (a - b), 10 and, 11 xor
//   result          WIDTH-bit result, wraps modulo 2^WIDTH
//   carry_overflow  signed overflow for add/sub, 0 for logic ops
module alu #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       control,
    output logic [WIDTH-1:0] result,
    output logic             carry_overflow
);

    always_comb begin
        result         = '0;
        carry_overflow = 1'b0;
        case (control)
            2'b00: begin
                result         = a + b;
                carry_overflow = (a[WIDTH-1] == b[WIDTH-1]) &&
                                 (result[WIDTH-1] != a[WIDTH-1]);
            end
            2'b01: begin
                result         = a - b;
                carry_overflow = (a[WIDTH-1] != b[WIDTH-1]) &&
                                 (result[WIDTH-1] != a[WIDTH-1]);
            end
            2'b10: result = a & b;
            default: result = a ^ b;
        endcase
    end

endmodule

// File: rtl/y86_cond_eval.sv
// y86_cond_eval: branch / conditional-move condition from the CC flags.
//   ifun        condition code (0 always .. 6 greater); codes above 6 never hold
//   zf, sf, of  current condition-code register
//   cnd         condition result
module y86_cond_eval
    import y86_pkg::*;
(
    input  logic [3:0] ifun,
    input  logic       zf,
    input  logic       sf,
    input  logic       of,
    output logic       cnd
);

    logic lt;
    assign lt = sf ^ of;

    always_comb begin
        cnd = 1'b0;
        case (ifun)
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = lt | zf;
            C_L:     cnd = lt;
            C_E:     cnd = zf;
            C_NE:    cnd = !zf;
            C_GE:    cnd = !lt;
            C_G:     cnd = !lt & !zf;
            default: cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/y86_execute_stage.sv
// y86_execute_stage: Execute stage of the Y86-64 pipeline.
// Selects ALU operands, keeps the ZF/SF/OF condition codes, evaluates
// JXX/CMOVXX conditions and registers the result into the E->M register.
//   clk, reset_n              clock, synchronous active-low reset
//   in_valid/in_ready         handshake from decode
//   flush                     squash output register and same-cycle accept
//   icode, ifun, valA, valB, valC, dstE, dstM   decoded instruction
//   out_valid/out_ready       handshake to memory stage
//   out_icode, out_cnd, out_valE, out_valA, out_dstE, out_dstM   E->M register
//   cc_zf, cc_sf, cc_of       condition-code register
// Optional: define Y86_EXEC_STATS_EN to add stat_instr / stat_taken
// saturating counters (accepted instructions / taken JXX).
module y86_execute_stage
    import y86_pkg::*;
#(
    parameter int         WORD_W = 64,
    parameter logic [3:0] RNONE  = R_NONE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [WORD_W-1:0] valA,
    input  logic [WORD_W-1:0] valB,
    input  logic [WORD_W-1:0] valC,
    input  logic [3:0]        dstE,
    input  logic [3:0]        dstM,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_icode,
    output logic              out_cnd,
    output logic [WORD_W-1:0] out_valE,
    output logic [WORD_W-1:0] out_valA,
    output logic [3:0]        out_dstE,
    output logic [3:0]        out_dstM,
    output logic              cc_zf,
    output logic              cc_sf,
    output logic              cc_of
`ifdef Y86_EXEC_STATS_EN
    ,
    output logic [31:0]       stat_instr,
    output logic [31:0]       stat_taken
`endif
);

    localparam logic [WORD_W-1:0] STEP_UP   = WORD_W'(8);
    localparam logic [WORD_W-1:0] STEP_DOWN = ~(WORD_W'(7));  // -8

    logic              accept;
    logic [WORD_W-1:0] alu_a, alu_b, alu_res, val_e;
    logic [1:0]        alu_ctl;
    logic              alu_ovf, use_alu;
    logic              cond_raw, cnd, is_cond;
    logic [3:0]        dst_e_sel;

    assign in_ready = !out_valid | out_ready;
    assign accept   = in_valid & in_ready & !flush;

    // Operand select: ALU computes alu_b OP alu_a.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_ctl = ALU_ADD;
        use_alu = 1'b1;
        case (icode)
            I_OPQ: begin
                alu_a   = valA;
                alu_b   = valB;
                alu_ctl = ifun[1:0];
            end
            I_RRMOVQ: alu_a = valA;
            I_IRMOVQ: alu_a = valC;
            I_RMMOVQ, I_MRMOVQ: begin
                alu_a = valC;
                alu_b = valB;
            end
            I_CALL, I_PUSHQ: begin
                alu_a = STEP_DOWN;
                alu_b = valB;
            end
            I_RET, I_POPQ: begin
                alu_a = STEP_UP;
                alu_b = valB;
            end
            default: use_alu = 1'b0;
        endcase
    end

    alu #(.WIDTH(WORD_W)) u_alu (
        .a              (alu_b),
        .b              (alu_a),
        .control        (alu_ctl),
        .result         (alu_res),
        .carry_overflow (alu_ovf)
    );

    assign val_e = use_alu ? alu_res : '0;

    // Conditions use the CC value held before this edge.
    y86_cond_eval u_cond (
        .ifun (ifun),
        .zf   (cc_zf),
        .sf   (cc_sf),
        .of   (cc_of),
        .cnd  (cond_raw)
    );

    assign is_cond   = (icode == I_JXX) || (icode == I_CMOVXX);
    assign cnd       = is_cond ? cond_raw : 1'b1;
    assign dst_e_sel = (icode == I_CMOVXX && !cnd) ? RNONE : dstE;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_icode <= '0;
            out_cnd   <= 1'b0;
            out_valE  <= '0;
            out_valA  <= '0;
            out_dstE  <= RNONE;
            out_dstM  <= RNONE;
            cc_zf     <= 1'b1;
            cc_sf     <= 1'b0;
            cc_of     <= 1'b0;
        end else if (flush) begin
            // Data fields are left as-is; only the valid bit matters.
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_icode <= icode;
            out_cnd   <= cnd;
            out_valE  <= val_e;
            out_valA  <= valA;
            out_dstE  <= dst_e_sel;
            out_dstM  <= dstM;
            if (icode == I_OPQ) begin
                cc_zf <= (val_e == '0);
                cc_sf <= val_e[WORD_W-1];
                cc_of <= alu_ovf & ((alu_ctl == ALU_ADD) || (alu_ctl == ALU_SUB));
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef Y86_EXEC_STATS_EN
    // accept already excludes flush cycles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_instr <= '0;
            stat_taken <= '0;
        end else if (accept) begin
            if (stat_instr != 32'hFFFF_FFFF)
                stat_instr <= stat_instr + 32'd1;
            if (icode == I_JXX && cnd && stat_taken != 32'hFFFF_FFFF)
                stat_taken <= stat_taken + 32'd1;
        end
    end
`endif

endmodule
